// File: rtl/alarm_unit.sv
// Alarm stage: holds the user-set alarm time, compares it with the running BCD time and drives the ring/buzzer.
// Optional snooze support is compiled in with `define ALARM_SNOOZE_EN.
module alarm_unit #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       sec_tick,
   input  logic [3:0] hours1,
   input  logic [3:0] hours2,
   input  logic [3:0] mins1,
   input  logic [3:0] mins2,
   input  logic       set_btn,
   input  logic       arm_btn,
   input  logic       hr_btn,
   input  logic       min_btn,
   input  logic       stop_btn,
   input  logic       snooze_btn,
   output logic [3:0] al_h1,
   output logic [3:0] al_h2,
   output logic [3:0] al_m1,
   output logic [3:0] al_m2,
   output logic       armed,
   output logic       editing,
   output logic       ringing,
   output logic       snoozing,
   output logic       buzzer
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_EDIT    = 2'd1;
   localparam logic [1:0] ST_RINGING = 2'd2;
`ifdef ALARM_SNOOZE_EN
   localparam logic [1:0] ST_SNOOZE  = 2'd3;
   localparam logic [8:0] SNOOZE_LIMIT = 9'(SNOOZE_SECS);
`endif
   localparam logic [8:0] RING_LIMIT = 9'(RING_SECS);

   logic [1:0] state;
   logic [1:0] state_next;
   logic       armed_next;
   logic       buzzer_next;
   logic       match;
   logic       match_prev;
   logic       match_rise;
   logic [8:0] count;
   logic [8:0] count_next;
   logic [8:0] count_inc;
   logic [3:0] al_h1_next;
   logic [3:0] al_h2_next;
   logic [3:0] al_m1_next;
   logic [3:0] al_m2_next;

   assign count_inc  = (count == 9'h1FF) ? count : count + 9'd1;
   assign match_rise = match & ~match_prev;

   // Alarm-time editing: minutes and hours roll independently, no carry between them
   always_comb begin
      al_h1_next = al_h1;
      al_h2_next = al_h2;
      al_m1_next = al_m1;
      al_m2_next = al_m2;
      if (state == ST_EDIT && min_btn) begin
         if (al_m2 == 4'd9) begin
            al_m2_next = 4'd0;
            al_m1_next = (al_m1 == 4'd5) ? 4'd0 : al_m1 + 4'd1;
         end else begin
            al_m2_next = al_m2 + 4'd1;
         end
      end
      if (state == ST_EDIT && hr_btn) begin
         if (al_h1 == 4'd2 && al_h2 == 4'd3) begin
            al_h1_next = 4'd0;
            al_h2_next = 4'd0;
         end else if (al_h2 == 4'd9) begin
            al_h2_next = 4'd0;
            al_h1_next = al_h1 + 4'd1;
         end else begin
            al_h2_next = al_h2 + 4'd1;
         end
      end
   end

   // Main mode control; buttons always outrank a same-cycle tick or match edge
   always_comb begin
      state_next  = state;
      armed_next  = armed;
      buzzer_next = buzzer;
      count_next  = count;
      case (state)
         ST_IDLE: begin
            if (arm_btn) begin
               armed_next = ~armed;
            end
            if (set_btn) begin
               state_next = ST_EDIT;
            end else if (!arm_btn && armed && match_rise) begin
               state_next  = ST_RINGING;
               count_next  = 9'd0;
               buzzer_next = 1'b1;
            end
         end
         ST_EDIT: begin
            if (set_btn) begin
               state_next = ST_IDLE;
            end
         end
         ST_RINGING: begin
            if (stop_btn) begin
               state_next  = ST_IDLE;
               buzzer_next = 1'b0;
               count_next  = 9'd0;
            end else if (arm_btn) begin
               state_next  = ST_IDLE;
               armed_next  = 1'b0;
               buzzer_next = 1'b0;
               count_next  = 9'd0;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze_btn) begin
               state_next  = ST_SNOOZE;
               buzzer_next = 1'b0;
               count_next  = 9'd0;
`endif
            end else if (sec_tick) begin
               if (count_inc >= RING_LIMIT) begin
                  state_next  = ST_IDLE;
                  buzzer_next = 1'b0;
                  count_next  = 9'd0;
               end else begin
                  buzzer_next = ~buzzer;
                  count_next  = count_inc;
               end
            end
         end
`ifdef ALARM_SNOOZE_EN
         ST_SNOOZE: begin
            if (stop_btn) begin
               state_next = ST_IDLE;
               count_next = 9'd0;
            end else if (arm_btn) begin
               state_next = ST_IDLE;
               armed_next = 1'b0;
               count_next = 9'd0;
            end else if (sec_tick) begin
               if (count_inc >= SNOOZE_LIMIT) begin
                  state_next  = ST_RINGING;
                  buzzer_next = 1'b1;
                  count_next  = 9'd0;
               end else begin
                  count_next = count_inc;
               end
            end
         end
`endif
         default: begin
            state_next  = ST_IDLE;
            buzzer_next = 1'b0;
            count_next  = 9'd0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_IDLE;
         armed      <= 1'b0;
         buzzer     <= 1'b0;
         count      <= 9'd0;
         match      <= 1'b0;
         match_prev <= 1'b0;
         al_h1      <= 4'd0;
         al_h2      <= 4'd0;
         al_m1      <= 4'd0;
         al_m2      <= 4'd0;
      end else begin
         state      <= state_next;
         armed      <= armed_next;
         buzzer     <= buzzer_next;
         count      <= count_next;
         match      <= (hours1 == al_h1) && (hours2 == al_h2) &&
                       (mins1 == al_m1) && (mins2 == al_m2);
         match_prev <= match;
         al_h1      <= al_h1_next;
         al_h2      <= al_h2_next;
         al_m1      <= al_m1_next;
         al_m2      <= al_m2_next;
      end
   end

   assign editing = (state == ST_EDIT);
   assign ringing = (state == ST_RINGING);

`ifdef ALARM_SNOOZE_EN
   assign snoozing = (state == ST_SNOOZE);
`else
   logic unused_snooze;
   assign unused_snooze = snooze_btn ^ (SNOOZE_SECS != 0);
   assign snoozing      = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_unit.sv
// Self-checking bench for alarm_unit: directed scenarios plus randomized traffic against an integer-level model.
// Honours `define ALARM_SNOOZE_EN in the same way as the design.
module tb_alarm_unit;

   localparam int RING_SECS   = 4;
   localparam int SNOOZE_SECS = 3;

   localparam int B_SET = 1;
   localparam int B_ARM = 2;
   localparam int B_HR  = 4;
   localparam int B_MIN = 8;
   localparam int B_STP = 16;
   localparam int B_SNZ = 32;

   typedef enum int {M_IDLE, M_EDIT, M_RING, M_SNOOZE} mode_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sec_tick = 1'b0;
   logic [3:0] hours1, hours2, mins1, mins2;
   logic       set_btn = 1'b0, arm_btn = 1'b0, hr_btn = 1'b0, min_btn = 1'b0;
   logic       stop_btn = 1'b0, snooze_btn = 1'b0;
   logic [3:0] al_h1, al_h2, al_m1, al_m2;
   logic       armed, editing, ringing, snoozing, buzzer;

   int tHour = 12;
   int tMin  = 0;

   mode_t mState = M_IDLE;
   bit    mArmed = 0;
   int    alH = 0;
   int    alM = 0;
   bit    mMatch = 0;
   bit    mMatchPrev = 0;
   int    mElapsed = 0;

   int compared = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   always_comb begin
      hours1 = 4'(tHour / 10);
      hours2 = 4'(tHour % 10);
      mins1  = 4'(tMin / 10);
      mins2  = 4'(tMin % 10);
   end

   alarm_unit #(.RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)) dut (
      .clock(clock), .reset(reset), .sec_tick(sec_tick),
      .hours1(hours1), .hours2(hours2), .mins1(mins1), .mins2(mins2),
      .set_btn(set_btn), .arm_btn(arm_btn), .hr_btn(hr_btn), .min_btn(min_btn),
      .stop_btn(stop_btn), .snooze_btn(snooze_btn),
      .al_h1(al_h1), .al_h2(al_h2), .al_m1(al_m1), .al_m2(al_m2),
      .armed(armed), .editing(editing), .ringing(ringing),
      .snoozing(snoozing), .buzzer(buzzer)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour in terms of whole hours/minutes and elapsed seconds
   task automatic modelStep();
      bit rise;
      bit nowMatch;
      if (reset) begin
         mState = M_IDLE; mArmed = 0; alH = 0; alM = 0;
         mMatch = 0; mMatchPrev = 0; mElapsed = 0;
         return;
      end
      nowMatch = (tHour == alH) && (tMin == alM);
      rise = mMatch && !mMatchPrev;
      case (mState)
         M_IDLE: begin
            if (arm_btn) mArmed = !mArmed;
            if (set_btn) mState = M_EDIT;
            else if (!arm_btn && mArmed && rise) begin
               mState = M_RING;
               mElapsed = 0;
            end
         end
         M_EDIT: begin
            if (min_btn) alM = (alM + 1) % 60;
            if (hr_btn) alH = (alH + 1) % 24;
            if (set_btn) mState = M_IDLE;
         end
         M_RING: begin
            if (stop_btn) mState = M_IDLE;
            else if (arm_btn) begin
               mState = M_IDLE;
               mArmed = 0;
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze_btn) begin
               mState = M_SNOOZE;
               mElapsed = 0;
            end
`endif
            else if (sec_tick) begin
               mElapsed++;
               if (mElapsed >= RING_SECS) mState = M_IDLE;
            end
         end
         M_SNOOZE: begin
            if (stop_btn) mState = M_IDLE;
            else if (arm_btn) begin
               mState = M_IDLE;
               mArmed = 0;
            end else if (sec_tick) begin
               mElapsed++;
               if (mElapsed >= SNOOZE_SECS) begin
                  mState = M_RING;
                  mElapsed = 0;
               end
            end
         end
         default: mState = M_IDLE;
      endcase
      mMatchPrev = mMatch;
      mMatch = nowMatch;
   endtask

   task automatic checkAll();
      checkOutput("al_h1", 8'(al_h1), 8'(alH / 10));
      checkOutput("al_h2", 8'(al_h2), 8'(alH % 10));
      checkOutput("al_m1", 8'(al_m1), 8'(alM / 10));
      checkOutput("al_m2", 8'(al_m2), 8'(alM % 10));
      checkOutput("armed", 8'(armed), 8'(mArmed));
      checkOutput("editing", 8'(editing), 8'(mState == M_EDIT));
      checkOutput("ringing", 8'(ringing), 8'(mState == M_RING));
      checkOutput("snoozing", 8'(snoozing), 8'(mState == M_SNOOZE));
      checkOutput("buzzer", 8'(buzzer), 8'((mState == M_RING) && (mElapsed % 2 == 0)));
   endtask

   // One clock cycle: drive pulses, advance the model at the edge, compare just after it
   task automatic applyStimulus(input int btns, input bit tick);
      set_btn    = (btns & B_SET) != 0;
      arm_btn    = (btns & B_ARM) != 0;
      hr_btn     = (btns & B_HR) != 0;
      min_btn    = (btns & B_MIN) != 0;
      stop_btn   = (btns & B_STP) != 0;
      snooze_btn = (btns & B_SNZ) != 0;
      sec_tick   = tick;
      @(posedge clock);
      modelStep();
      #1;
      checkAll();
      set_btn = 0; arm_btn = 0; hr_btn = 0; min_btn = 0;
      stop_btn = 0; snooze_btn = 0; sec_tick = 0;
   endtask

   task automatic repeatStim(input int n, input int btns, input bit tick);
      for (int i = 0; i < n; i++) applyStimulus(btns, tick);
   endtask

   task automatic setTime(input int h, input int m);
      tHour = h;
      tMin = m;
   endtask

   initial begin
      int sel;
      int t;
      #2;
      repeatStim(2, 0, 0);
      reset = 0;
      checkOutput("reset_ringing", 8'(ringing), 8'd0);

      $display("[TB] alarm set and ring");
      applyStimulus(B_SET, 0);
      repeatStim(7, B_HR, 0);
      repeatStim(30, B_MIN, 0);
      applyStimulus(B_SET, 0);
      checkOutput("set_h1", 8'(al_h1), 8'd0);
      checkOutput("set_h2", 8'(al_h2), 8'd7);
      checkOutput("set_m1", 8'(al_m1), 8'd3);
      checkOutput("set_m2", 8'(al_m2), 8'd0);
      applyStimulus(B_ARM, 0);
      setTime(7, 29);
      repeatStim(3, 0, 0);
      setTime(7, 30);
      applyStimulus(0, 0);
      checkOutput("ring_lat1", 8'(ringing), 8'd0);
      applyStimulus(0, 0);
      checkOutput("ring_lat2", 8'(ringing), 8'd1);
      checkOutput("ring_buz0", 8'(buzzer), 8'd1);
      applyStimulus(0, 1);
      checkOutput("ring_buz1", 8'(buzzer), 8'd0);
      applyStimulus(0, 1);
      checkOutput("ring_buz2", 8'(buzzer), 8'd1);

      $display("[TB] stop without re-ring");
      applyStimulus(B_STP, 0);
      repeatStim(10, 0, 1);
      checkOutput("stop_hold", 8'(ringing), 8'd0);
      setTime(7, 31);
      repeatStim(2, 0, 0);
      setTime(7, 30);
      repeatStim(2, 0, 0);
      checkOutput("rering", 8'(ringing), 8'd1);

      $display("[TB] timeout");
      repeatStim(RING_SECS, 0, 1);
      checkOutput("tmo_ringing", 8'(ringing), 8'd0);
      checkOutput("tmo_buzzer", 8'(buzzer), 8'd0);
      checkOutput("tmo_armed", 8'(armed), 8'd1);

      $display("[TB] snooze");
      setTime(7, 31);
      repeatStim(2, 0, 0);
      setTime(7, 30);
      repeatStim(2, 0, 0);
      applyStimulus(B_SNZ, 0);
`ifdef ALARM_SNOOZE_EN
      checkOutput("snz_on", 8'(snoozing), 8'd1);
      repeatStim(SNOOZE_SECS - 1, 0, 1);
      checkOutput("snz_hold", 8'(snoozing), 8'd1);
      applyStimulus(0, 1);
      checkOutput("snz_back", 8'(ringing), 8'd1);
`else
      checkOutput("snz_ignored", 8'(ringing), 8'd1);
      checkOutput("snz_tied", 8'(snoozing), 8'd0);
`endif

      $display("[TB] reset mid-ring");
      reset = 1;
      applyStimulus(0, 0);
      reset = 0;
      checkOutput("rst_ringing", 8'(ringing), 8'd0);
      checkOutput("rst_armed", 8'(armed), 8'd0);
      checkOutput("rst_alh2", 8'(al_h2), 8'd0);
      checkOutput("rst_alm1", 8'(al_m1), 8'd0);

      $display("[TB] edit wraps");
      applyStimulus(B_SET, 0);
      repeatStim(60, B_MIN, 0);
      checkOutput("wrap_m1", 8'(al_m1), 8'd0);
      checkOutput("wrap_m2", 8'(al_m2), 8'd0);
      repeatStim(24, B_HR, 0);
      checkOutput("wrap_h1", 8'(al_h1), 8'd0);
      checkOutput("wrap_h2", 8'(al_h2), 8'd0);
      repeatStim(10, B_MIN, 0);
      checkOutput("ten_m1", 8'(al_m1), 8'd1);
      checkOutput("ten_m2", 8'(al_m2), 8'd0);
      applyStimulus(B_HR | B_MIN, 0);
      applyStimulus(B_SET, 0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 11) == 0) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) setTime(alH, alM);
            else if (sel == 1) begin
               t = (alH * 60 + alM + 1) % 1440;
               setTime(t / 60, t % 60);
            end else setTime($urandom_range(0, 23), $urandom_range(0, 59));
         end
         case ($urandom_range(0, 39))
            0: sel = B_SET;
            1: sel = B_ARM;
            2: sel = B_HR;
            3: sel = B_MIN;
            4: sel = B_STP;
            5: sel = B_SNZ;
            6: sel = B_HR | B_MIN;
            default: sel = 0;
         endcase
         if (sel == B_ARM && mState == M_IDLE && mMatch && !mMatchPrev) sel = 0;
         applyStimulus(sel, $urandom_range(0, 3) == 0);
      end
      reset = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
